// File: rtl/serial_twos_negator.sv
// Bit-serial two's-complement pass/negate/abs unit with valid/ready handshakes.
// One word is processed LSB-first, one bit per clock, then held until the consumer takes it.
module serial_twos_negator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_one_q, seen_one_d;
    logic             inv_en_q, inv_en_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_zero_q, out_zero_d;

    logic             in_bit;
    logic             out_bit;
    logic             accept_inv;

    // Serial negation: copy bits up to and including the first 1, invert everything above it.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        seen_one_d = seen_one_q;
        inv_en_d   = inv_en_q;
        ovf_pend_d = ovf_pend_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_zero_d = out_zero_q;
        in_bit     = 1'b0;
        out_bit    = 1'b0;
        accept_inv = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_inv = (in_mode == 2'b01) |
                                 ((in_mode == 2'b10) & in_data[WIDTH-1]);
                    sreg_d     = in_data;
                    res_d      = '0;
                    cnt_d      = '0;
                    seen_one_d = 1'b0;
                    inv_en_d   = accept_inv;
                    ovf_pend_d = accept_inv & (in_data == MOST_NEG);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                in_bit     = sreg_q[0];
                out_bit    = (inv_en_q & seen_one_q) ? ~in_bit : in_bit;
                seen_one_d = seen_one_q | in_bit;
                res_d      = {out_bit, res_q[WIDTH-1:1]};
                sreg_d     = {1'b0, sreg_q[WIDTH-1:1]};
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    out_data_d = res_d;
                    out_zero_d = (res_d == '0);
                    out_ovf_d  = ovf_pend_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            inv_en_q   <= 1'b0;
            ovf_pend_q <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            seen_one_q <= seen_one_d;
            inv_en_q   <= inv_en_d;
            ovf_pend_q <= ovf_pend_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            out_zero_q <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_serial_twos_negator.sv
// Scoreboard bench for serial_twos_negator: a 4-bit instance for most scenarios
// and an 8-bit instance for the wider-word latency and result checks.
module tb_serial_twos_negator;

    logic clk;
    logic rst_n;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4, out_zero4, busy4;
    logic [3:0] in_data4, out_data4;
    logic [1:0] in_mode4;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_ovf8, out_zero8, busy8;
    logic [7:0] in_data8, out_data8;
    logic [1:0] in_mode8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] data;
        logic       ovf;
        logic       zero;
    } exp4_t;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic       zero;
    } exp8_t;

    exp4_t sb4[$];
    exp8_t sb8[$];

    serial_twos_negator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_ovf(out_ovf4), .out_zero(out_zero4), .busy(busy4)
    );

    serial_twos_negator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_ovf(out_ovf8), .out_zero(out_zero8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: two's-complement negate modulo 2^WIDTH, no bit-serial logic.
    function automatic exp4_t model4(input logic [3:0] x, input logic [1:0] m);
        exp4_t e;
        logic  inv;
        inv    = (m == 2'b01) || ((m == 2'b10) && x[3]);
        e.data = inv ? 4'(4'd0 - x) : x;
        e.ovf  = inv && (x == 4'b1000);
        e.zero = (e.data == 4'd0);
        return e;
    endfunction

    function automatic exp8_t model8(input logic [7:0] x, input logic [1:0] m);
        exp8_t e;
        logic  inv;
        inv    = (m == 2'b01) || ((m == 2'b10) && x[7]);
        e.data = inv ? 8'(8'd0 - x) : x;
        e.ovf  = inv && (x == 8'h80);
        e.zero = (e.data == 8'd0);
        return e;
    endfunction

    // Caller is at a negedge. Drives one word, keeps junk on the inputs while busy,
    // optionally stalls the consumer for 'hold' cycles, then completes the transfer.
    task automatic run_word4(input logic [3:0] data, input logic [1:0] mode, input int hold,
                             input bit check_lat, input bit need_ready);
        exp4_t e;
        int    lat;
        bit    seen;
        sb4.push_back(model4(data, mode));
        in_valid4  = 1'b1;
        in_data4   = data;
        in_mode4   = mode;
        out_ready4 = 1'b0;
        if (need_ready) begin
            n_cmp++;
            if (in_ready4 !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL next_word_ready: in_ready=%b required 1", in_ready4);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready4 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1 within 10 cycles", in_ready4);
            in_valid4 = 1'b0;
            void'(sb4.pop_back());
            return;
        end
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            in_data4 = 4'($urandom_range(15, 0));
            in_mode4 = 2'($urandom_range(3, 0));
            if (out_valid4 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL result_timeout: out_valid=%b required 1 within 40 cycles", out_valid4);
            in_valid4 = 1'b0;
            void'(sb4.pop_front());
            return;
        end
        if (check_lat) begin
            n_cmp++;
            if (lat != 5) begin
                n_bad++;
                $display("[TB] FAIL latency4: out_valid at T+%0d required T+5", lat);
            end
        end
        e = sb4.pop_front();
        n_cmp++;
        if ({out_data4, out_ovf4, out_zero4} !== {e.data, e.ovf, e.zero}) begin
            n_bad++;
            $display("[TB] FAIL result4 in=%b mode=%b: data=%b ovf=%b zero=%b required data=%b ovf=%b zero=%b",
                     data, mode, out_data4, out_ovf4, out_zero4, e.data, e.ovf, e.zero);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid4, in_ready4, out_data4, out_ovf4, out_zero4} !== {1'b1, 1'b0, e.data, e.ovf, e.zero}) begin
                n_bad++;
                $display("[TB] FAIL stall_hold cycle %0d: valid=%b ready=%b data=%b ovf=%b zero=%b required 1 0 %b %b %b",
                         i, out_valid4, in_ready4, out_data4, out_ovf4, out_zero4, e.data, e.ovf, e.zero);
            end
        end
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
        in_valid4  = 1'b0;
        n_cmp++;
        if ({out_valid4, in_ready4, busy4} !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL after_transfer4: valid/ready/busy=%b required 010", {out_valid4, in_ready4, busy4});
        end
    endtask

    task automatic run_word8(input logic [7:0] data, input logic [1:0] mode, input bit check_lat);
        exp8_t e;
        int    lat;
        bit    seen;
        sb8.push_back(model8(data, mode));
        in_valid8  = 1'b1;
        in_data8   = data;
        in_mode8   = mode;
        out_ready8 = 1'b0;
        n_cmp++;
        if (in_ready8 !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL ready8: in_ready=%b required 1", in_ready8);
            in_valid8 = 1'b0;
            void'(sb8.pop_back());
            return;
        end
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            in_valid8 = 1'b0;
            in_data8  = 8'($urandom_range(255, 0));
            if (out_valid8 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL result8_timeout: out_valid=%b required 1 within 40 cycles", out_valid8);
            void'(sb8.pop_front());
            return;
        end
        if (check_lat) begin
            n_cmp++;
            if (lat != 9) begin
                n_bad++;
                $display("[TB] FAIL latency8: out_valid at T+%0d required T+9", lat);
            end
        end
        e = sb8.pop_front();
        n_cmp++;
        if ({out_data8, out_ovf8, out_zero8} !== {e.data, e.ovf, e.zero}) begin
            n_bad++;
            $display("[TB] FAIL result8 in=%h mode=%b: data=%h ovf=%b zero=%b required data=%h ovf=%b zero=%b",
                     data, mode, out_data8, out_ovf8, out_zero8, e.data, e.ovf, e.zero);
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid4  = 1'b0; in_data4 = '0; in_mode4 = '0; out_ready4 = 1'b0;
        in_valid8  = 1'b0; in_data8 = '0; in_mode8 = '0; out_ready8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid4, in_ready4, busy4, out_data4, out_ovf4, out_zero4} !== {3'b010, 4'b0000, 2'b00}) begin
            n_bad++;
            $display("[TB] FAIL reset_state4: valid=%b ready=%b busy=%b data=%b ovf=%b zero=%b required 0 1 0 0000 0 0",
                     out_valid4, in_ready4, busy4, out_data4, out_ovf4, out_zero4);
        end
        n_cmp++;
        if ({out_valid8, in_ready8, busy8, out_data8} !== {3'b010, 8'h00}) begin
            n_bad++;
            $display("[TB] FAIL reset_state8: valid=%b ready=%b busy=%b data=%h required 0 1 0 00",
                     out_valid8, in_ready8, busy8, out_data8);
        end
    endtask

    task automatic test_negate();
        run_word4(4'b0011, 2'b01, 0, 1'b1, 1'b1);
        run_word4(4'b0110, 2'b01, 0, 1'b0, 1'b0);
        run_word4(4'b1111, 2'b01, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abs_and_pass();
        run_word4(4'b1010, 2'b10, 0, 1'b0, 1'b0);
        run_word4(4'b0101, 2'b10, 0, 1'b0, 1'b0);
        run_word4(4'b1010, 2'b11, 0, 1'b0, 1'b0);
        run_word4(4'b1001, 2'b00, 0, 1'b0, 1'b0);
    endtask

    task automatic test_boundaries();
        run_word4(4'b1000, 2'b01, 0, 1'b0, 1'b0);
        run_word4(4'b0000, 2'b01, 0, 1'b0, 1'b0);
        run_word4(4'b1000, 2'b10, 0, 1'b0, 1'b0);
        run_word4(4'b1000, 2'b00, 0, 1'b0, 1'b0);
        run_word4(4'b0000, 2'b10, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_word4(4'b0111, 2'b01, 6, 1'b0, 1'b0);
        run_word4(4'b1100, 2'b10, 0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_word4(4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)), i % 3, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit stray;
        in_valid4 = 1'b1;
        in_data4  = 4'b0011;
        in_mode4  = 2'b01;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid4, in_ready4, busy4, out_data4} !== {3'b010, 4'b0000}) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_shift: valid=%b ready=%b busy=%b data=%b required 0 1 0 0000",
                     out_valid4, in_ready4, busy4, out_data4);
        end
        stray = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (out_valid4 !== 1'b0) stray = 1'b1;
        end
        n_cmp++;
        if (stray) begin
            n_bad++;
            $display("[TB] FAIL discarded_word: out_valid=1 seen after reset, required 0");
        end
    endtask

    task automatic test_reset_mid_done();
        bit seen;
        in_valid4  = 1'b1;
        in_data4   = 4'b0101;
        in_mode4   = 2'b01;
        out_ready4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid4 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL done_timeout: out_valid=%b required 1 within 20 cycles", out_valid4);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid4, in_ready4, busy4, out_data4} !== {3'b010, 4'b0000}) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_done: valid=%b ready=%b busy=%b data=%b required 0 1 0 0000",
                     out_valid4, in_ready4, busy4, out_data4);
        end
    endtask

    task automatic test_width8();
        run_word8(8'h01, 2'b01, 1'b1);
        run_word8(8'h80, 2'b10, 1'b0);
        run_word8(8'hC3, 2'b10, 1'b0);
        run_word8(8'h00, 2'b01, 1'b0);
        run_word8(8'h5A, 2'b11, 1'b0);
    endtask

    initial begin
        test_reset();
        test_negate();
        test_abs_and_pass();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        test_reset_mid_done();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
